// File: rtl/fp_wire.sv
// ---------------------------------------------------------------------------
// fp_wire: shared FP min/max operand types and constants.
//   fp_max_in_type : record consumed by the FP min/max datapath.
//   fp_prep_type   : single-operand prep result {data, ext, cls}.
//   FP_CLASS_*     : one-hot class bit positions (RISC-V fclass order).
//   FP_CNAN_S/D    : canonical quiet NaNs (single NaN-boxing-free form, double).
// ---------------------------------------------------------------------------
package fp_wire;

    localparam int unsigned FP_XLEN    = 64;
    localparam int unsigned FP_EXT_W   = 65;
    localparam int unsigned FP_CLASS_W = 10;

    localparam int unsigned FP_CLASS_NINF  = 0;
    localparam int unsigned FP_CLASS_NNORM = 1;
    localparam int unsigned FP_CLASS_NSUB  = 2;
    localparam int unsigned FP_CLASS_NZERO = 3;
    localparam int unsigned FP_CLASS_PZERO = 4;
    localparam int unsigned FP_CLASS_PSUB  = 5;
    localparam int unsigned FP_CLASS_PNORM = 6;
    localparam int unsigned FP_CLASS_PINF  = 7;
    localparam int unsigned FP_CLASS_SNAN  = 8;
    localparam int unsigned FP_CLASS_QNAN  = 9;

    localparam logic [FP_XLEN-1:0] FP_CNAN_S = 64'h0000_0000_7FC0_0000;
    localparam logic [FP_XLEN-1:0] FP_CNAN_D = 64'h7FF8_0000_0000_0000;

    typedef struct packed {
        logic [FP_XLEN-1:0]    data1;
        logic [FP_XLEN-1:0]    data2;
        logic [FP_EXT_W-1:0]   ext1;
        logic [FP_EXT_W-1:0]   ext2;
        logic [FP_CLASS_W-1:0] class1;
        logic [FP_CLASS_W-1:0] class2;
        logic [1:0]            fmt;
        logic [2:0]            rm;
    } fp_max_in_type;

    typedef struct packed {
        logic [FP_XLEN-1:0]    data;
        logic [FP_EXT_W-1:0]   ext;
        logic [FP_CLASS_W-1:0] cls;
    } fp_prep_type;

endpackage

// File: rtl/fp_max_prep_op.sv
// ---------------------------------------------------------------------------
// fp_max_prep_op: combinational single-operand prep (classify, extend,
// optional NaN-box check). Build option: FP_PREP_NANBOX_EN enables NaN-box
// checking with canonical-NaN substitution for single-precision operands.
//   data_i    : raw 64-bit register-file operand
//   fmt_i     : 0 = single, otherwise treated as double
//   prep_c_o  : {data, ext, cls} (combinational)
// ---------------------------------------------------------------------------
module fp_max_prep_op
    import fp_wire::*;
(
    input  logic [63:0] data_i,
    input  logic [1:0]  fmt_i,
    output fp_prep_type prep_c_o
);

    logic        is_single;
    logic [63:0] data;
    logic        sgn;
    logic        exp_ones;
    logic        exp_zero;
    logic        man_zero;
    logic        man_msb;
    logic [64:0] ext;
    logic [9:0]  cls;

    // Effective operand and its sign/exponent/mantissa summary
    always_comb begin
        is_single = (fmt_i == 2'd0);
        data      = data_i;
`ifdef FP_PREP_NANBOX_EN
        if (is_single && (data_i[63:32] != 32'hFFFF_FFFF)) begin
            data = FP_CNAN_S;
        end
`endif
        if (is_single) begin
            sgn      = data[31];
            exp_ones = &data[30:23];
            exp_zero = ~|data[30:23];
            man_zero = ~|data[22:0];
            man_msb  = data[22];
            ext      = {data[31], 33'b0, data[30:0]};
        end else begin
            sgn      = data[63];
            exp_ones = &data[62:52];
            exp_zero = ~|data[62:52];
            man_zero = ~|data[51:0];
            man_msb  = data[51];
            ext      = {data[63], 1'b0, data[62:0]};
        end
    end

    // One-hot fclass
    always_comb begin
        cls = '0;
        if (exp_ones) begin
            if (man_zero)     cls[sgn ? FP_CLASS_NINF : FP_CLASS_PINF] = 1'b1;
            else if (man_msb) cls[FP_CLASS_QNAN] = 1'b1;
            else              cls[FP_CLASS_SNAN] = 1'b1;
        end else if (exp_zero) begin
            if (man_zero)     cls[sgn ? FP_CLASS_NZERO : FP_CLASS_PZERO] = 1'b1;
            else              cls[sgn ? FP_CLASS_NSUB : FP_CLASS_PSUB] = 1'b1;
        end else begin
            cls[sgn ? FP_CLASS_NNORM : FP_CLASS_PNORM] = 1'b1;
        end
    end

    assign prep_c_o = '{data: data, ext: ext, cls: cls};

endmodule

// File: rtl/fp_max_prep.sv
// ---------------------------------------------------------------------------
// fp_max_prep: registered operand-prep stage ahead of the FP min/max unit.
// Build option: FP_PREP_NANBOX_EN (see fp_max_prep_op).
//   clk, rst_n             : clock, async active-low reset
//   flush_i                : synchronous kill of output and skid entries
//   in_valid_i/in_ready_o  : operand handshake (in_ready_o registered)
//   in_data1_i/in_data2_i  : raw operands; in_fmt_i, in_rm_i, in_tag_i
//   out_valid_o/out_ready_i: record handshake
//   fp_max_o, out_tag_o    : prepared record and its tag
// ---------------------------------------------------------------------------
module fp_max_prep
    import fp_wire::*;
#(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [63:0]      in_data1_i,
    input  logic [63:0]      in_data2_i,
    input  logic [1:0]       in_fmt_i,
    input  logic [2:0]       in_rm_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output fp_max_in_type    fp_max_o,
    output logic [TAG_W-1:0] out_tag_o
);

    fp_prep_type   prep1_c;
    fp_prep_type   prep2_c;
    fp_max_in_type in_rec_c;

    fp_max_prep_op u_op1 (.data_i(in_data1_i), .fmt_i(in_fmt_i), .prep_c_o(prep1_c));
    fp_max_prep_op u_op2 (.data_i(in_data2_i), .fmt_i(in_fmt_i), .prep_c_o(prep2_c));

    assign in_rec_c = '{data1: prep1_c.data, data2: prep2_c.data,
                        ext1: prep1_c.ext, ext2: prep2_c.ext,
                        class1: prep1_c.cls, class2: prep2_c.cls,
                        fmt: in_fmt_i, rm: in_rm_i};

    logic              out_valid_q, out_valid_d;
    fp_max_in_type     out_q, out_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic              skid_valid_q, skid_valid_d;
    fp_max_in_type     skid_q, skid_d;
    logic [TAG_W-1:0]  skid_tag_q, skid_tag_d;
    logic              in_ready_q, in_ready_d;

    logic in_xfer;
    logic out_load;

    // Output/skid steering; skid always drains before newer input
    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        out_tag_d    = out_tag_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        skid_tag_d   = skid_tag_q;
        in_xfer      = in_valid_i && in_ready_q;
        out_load     = !out_valid_q || out_ready_i;

        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_load) begin
            if (skid_valid_q) begin
                // in_ready_q is low whenever skid is full, so no input here
                out_d        = skid_q;
                out_tag_d    = skid_tag_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_xfer;
                if (in_xfer) begin
                    out_d     = in_rec_c;
                    out_tag_d = in_tag_i;
                end
            end
        end else if (in_xfer) begin
            skid_d       = in_rec_c;
            skid_tag_d   = in_tag_i;
            skid_valid_d = 1'b1;
        end

        in_ready_d = !skid_valid_d;
    end

    // Stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_tag_q   <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            out_tag_q    <= out_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            skid_tag_q   <= skid_tag_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign fp_max_o    = out_q;
    assign out_tag_o   = out_tag_q;

endmodule

// File: tb/tb_fp_max_prep.sv
// ---------------------------------------------------------------------------
// tb_fp_max_prep: directed vectors with a scoreboard queue; expectations are
// pushed on input acceptance and popped by a monitor on output transfer.
// ---------------------------------------------------------------------------
module tb_fp_max_prep;
    import fp_wire::*;

    localparam int unsigned TAG_W = 4;
    localparam int unsigned NV    = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [63:0]      in_data1_i;
    logic [63:0]      in_data2_i;
    logic [1:0]       in_fmt_i;
    logic [2:0]       in_rm_i;
    logic [TAG_W-1:0] in_tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    fp_max_in_type    fp_max_o;
    logic [TAG_W-1:0] out_tag_o;

    fp_max_prep #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_data1_i(in_data1_i), .in_data2_i(in_data2_i),
        .in_fmt_i(in_fmt_i), .in_rm_i(in_rm_i), .in_tag_i(in_tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .fp_max_o(fp_max_o), .out_tag_o(out_tag_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d1, d2;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic [63:0] x1, x2;
        logic [64:0] e1, e2;
        logic [9:0]  c1, c2;
    } vec_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        fp_max_in_type    rec;
    } exp_t;

    vec_t vt [NV];
    exp_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pops   = 0;

    function automatic vec_t mkv(input logic [63:0] d1, input logic [63:0] d2,
                                 input logic [1:0] fmt, input logic [2:0] rm,
                                 input logic [63:0] x1, input logic [64:0] e1,
                                 input logic [9:0] c1, input logic [64:0] e2,
                                 input logic [9:0] c2);
        vec_t v;
        v.d1 = d1; v.d2 = d2; v.fmt = fmt; v.rm = rm;
        v.x1 = x1; v.x2 = d2; v.e1 = e1; v.e2 = e2; v.c1 = c1; v.c2 = c2;
        return v;
    endfunction

    function automatic fp_max_in_type exp_rec(input vec_t v);
        fp_max_in_type r;
        r.data1 = v.x1; r.data2 = v.x2; r.ext1 = v.e1; r.ext2 = v.e2;
        r.class1 = v.c1; r.class2 = v.c2; r.fmt = v.fmt; r.rm = v.rm;
        return r;
    endfunction

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero_rec(input string name);
        n_checks++;
        if (fp_max_o !== '0 || out_tag_o !== '0) begin
            n_fail++;
            $display("FAIL %s: got rec=%h tag=%h expected all zero", name, fp_max_o, out_tag_o);
        end
    endtask

    task automatic drive(input int vi, input logic [TAG_W-1:0] tag);
        in_data1_i = vt[vi].d1;
        in_data2_i = vt[vi].d2;
        in_fmt_i   = vt[vi].fmt;
        in_rm_i    = vt[vi].rm;
        in_tag_i   = tag;
    endtask

    // Offer one vector, hold until accepted; returns cycles spent waiting
    task automatic send(input int vi, input logic [TAG_W-1:0] tag, output int waits);
        exp_t e;
        bit   acc;
        waits = 0;
        acc   = 1'b0;
        drive(vi, tag);
        in_valid_i = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready_o) begin
                e.tag = tag;
                e.rec = exp_rec(vt[vi]);
                sb.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk); #1;
            if (acc) break;
            waits++;
        end
        in_valid_i = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: tag %0h never accepted", tag);
        end
    endtask

    // Offer an input together with a flush pulse; nothing survives
    task automatic flush_cycle(input int vi, input logic [TAG_W-1:0] tag);
        drive(vi, tag);
        in_valid_i = 1'b1;
        flush_i    = 1'b1;
        @(negedge clk);
        sb.delete();
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        flush_i    = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 50; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid_o && out_ready_i) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got tag %0h expected none", out_tag_o);
            end else begin
                e = sb.pop_front();
                if (out_tag_o !== e.tag || fp_max_o !== e.rec) begin
                    n_fail++;
                    $display("FAIL out_record: got tag %0h rec %h expected tag %0h rec %h",
                             out_tag_o, fp_max_o, e.tag, e.rec);
                end
            end
            n_pops++;
        end
    end

    initial begin
        int w;
        int stall;
        int base;

        vt[0] = mkv(64'hFFFFFFFF3F800000, 64'hFFFFFFFF80000000, 2'd0, 3'd0,
                    64'hFFFFFFFF3F800000, 65'h0_000000003F800000, 10'h040,
                    65'h1_0000000000000000, 10'h008);
        vt[1] = mkv(64'h3FF0000000000000, 64'h8000000000000000, 2'd1, 3'd1,
                    64'h3FF0000000000000, 65'h0_3FF0000000000000, 10'h040,
                    65'h1_0000000000000000, 10'h008);
`ifdef FP_PREP_NANBOX_EN
        vt[2] = mkv(64'h000000003F800000, 64'hFFFFFFFF3F800000, 2'd0, 3'd1,
                    64'h000000007FC00000, 65'h0_000000007FC00000, 10'h200,
                    65'h0_000000003F800000, 10'h040);
`else
        vt[2] = mkv(64'h000000003F800000, 64'hFFFFFFFF3F800000, 2'd0, 3'd1,
                    64'h000000003F800000, 65'h0_000000003F800000, 10'h040,
                    65'h0_000000003F800000, 10'h040);
`endif
        vt[3] = mkv(64'hFFFFFFFF7F800001, 64'hFFFFFFFFFF800000, 2'd0, 3'd0,
                    64'hFFFFFFFF7F800001, 65'h0_000000007F800001, 10'h100,
                    65'h1_000000007F800000, 10'h001);
        vt[4] = mkv(64'h7FF0000000000000, 64'hFFF8000000000000, 2'd1, 3'd1,
                    64'h7FF0000000000000, 65'h0_7FF0000000000000, 10'h080,
                    65'h1_7FF8000000000000, 10'h200);
        vt[5] = mkv(64'h0000000000000001, 64'h8000000000000001, 2'd1, 3'd0,
                    64'h0000000000000001, 65'h0_0000000000000001, 10'h020,
                    65'h1_0000000000000001, 10'h004);
        vt[6] = mkv(64'hFFFFFFFFBF800000, 64'hFFFFFFFF00000000, 2'd0, 3'd1,
                    64'hFFFFFFFFBF800000, 65'h1_000000003F800000, 10'h002,
                    65'h0_0000000000000000, 10'h010);
        vt[7] = mkv(64'hC000000000000000, 64'h7FF0000000000001, 2'd2, 3'd5,
                    64'hC000000000000000, 65'h1_4000000000000000, 10'h002,
                    65'h0_7FF0000000000001, 10'h100);

        rst_n       = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        in_data1_i  = '0;
        in_data2_i  = '0;
        in_fmt_i    = '0;
        in_rm_i     = '0;
        in_tag_i    = '0;
        #12 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        chk("reset_out_valid", 64'(out_valid_o), 64'd0);
        chk("reset_in_ready", 64'(in_ready_o), 64'd1);
        chk_zero_rec("reset_record");

        // Back-to-back stream, full throughput
        out_ready_i = 1'b1;
        base  = n_pops;
        stall = 0;
        for (int i = 0; i < int'(NV); i++) begin
            send(i, TAG_W'(i), w);
            stall += w;
        end
        chk("stream_in_ready_never_low", 64'(stall), 64'd0);
        chk("stream_one_per_cycle", 64'(n_pops - base), 64'(NV - 1));
        @(posedge clk); #1;
        chk("stream_last_out", 64'(n_pops - base), 64'(NV));

        // Stall: output + skid fill, third input held off
        out_ready_i = 1'b0;
        send(2, 4'h8, w);
        send(3, 4'h9, w);
        chk("stall_in_ready_low", 64'(in_ready_o), 64'd0);
        chk("stall_out_valid", 64'(out_valid_o), 64'd1);
        drive(4, 4'hA);
        in_valid_i = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("stall_still_blocked", 64'(in_ready_o), 64'd0);
        end
        @(posedge clk); #1;
        out_ready_i = 1'b1;
        send(4, 4'hA, w);
        drain("stall_drain");

        // Flush with skid full and input offered
        out_ready_i = 1'b0;
        send(5, 4'h1, w);
        send(6, 4'h2, w);
        flush_cycle(7, 4'h3);
        chk("flush_full_out_valid", 64'(out_valid_o), 64'd0);
        chk("flush_full_in_ready", 64'(in_ready_o), 64'd1);

        // Flush with skid empty: the offered input is discarded
        send(0, 4'h4, w);
        flush_cycle(1, 4'h5);
        chk("flush_empty_out_valid", 64'(out_valid_o), 64'd0);
        chk("flush_empty_in_ready", 64'(in_ready_o), 64'd1);
        out_ready_i = 1'b1;
        send(3, 4'h6, w);
        drain("flush_drain");
        @(posedge clk); #1;
        chk("flush_no_ghost", 64'(out_valid_o), 64'd0);

        // Asynchronous reset mid-stream
        out_ready_i = 1'b0;
        send(4, 4'h7, w);
        send(5, 4'h8, w);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk_zero_rec("rst_record");
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_no_replay", 64'(out_valid_o), 64'd0);
        out_ready_i = 1'b1;
        send(6, 4'h9, w);
        drain("post_reset_drain");

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
